mcast_branch_sched: RTL and testbench
=====================================

MCAST_BRANCH_SCHED -- requirements
Module: mcast_branch_sched

Interface
REQ-001 SHALL have parameter MY_XPOS, default 0, meaning router column.
REQ-002 SHALL have parameter MY_YPOS, default 0, meaning router row.
REQ-003 SHALL have parameter XDIM, default 4, meaning mesh columns.
REQ-004 SHALL have parameter YDIM, default 4, meaning mesh rows; NN = XDIM*YDIM; node id = y*XDIM + x.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input flit valid
- in_ready  out  1  input flit consumed
- in_head  in  1  head flit marker
- in_tail  in  1  tail flit marker (head+tail = single-flit packet)
- in_dst  in  NN  multicast destination bitmask, valid with head
- sa_req  out  5  per-output-port request to switch allocator
- sa_gnt  in  5  per-port grant, single-cycle pulse
- sa_release  out  5  per-port release pulse
- port_dst  out  5*NN  per-port branch bitmask, slice p = [p*NN +: NN]
- out_valid  out  5  per-port flit valid
- out_ready  in  5  per-port downstream ready
- err_orphan  out  1  one-cycle pulse when a non-head flit arrives in IDLE
REQ-007 SHALL use port bit order [0]=L, [1]=N, [2]=E, [3]=S, [4]=W.

Function
REQ-008 SHALL partition the destination bitmask per node (x,y): x>MY_XPOS→E; x<MY_XPOS→W; x==MY_XPOS and y>MY_YPOS→N; y<MY_YPOS→S; equal→L.
REQ-009 SHALL implement states IDLE, ALLOC, XFER, DROP.
REQ-010 In IDLE with in_valid&in_head, SHALL register the partitioned port_dst and branch = OR-reduction per slice, leave the head unconsumed (in_ready=0), and go to ALLOC, or to DROP if branch==0.
REQ-011 In IDLE with in_valid&~in_head, SHALL assert in_ready=1, consume the flit, and pulse err_orphan.
REQ-012 In ALLOC, sa_req SHALL equal branch & ~lock; the lock register SHALL accumulate sa_gnt & sa_req each cycle; grants on unrequested bits SHALL be ignored.
REQ-013 The cycle after lock==branch, the block SHALL enter XFER; partial grants SHALL be held (no release) while waiting.
REQ-014 In XFER:
- out_valid = lock & {5{in_valid}}
- in_ready = &(out_ready | ~lock)
- a transfer occurs when in_valid & in_ready (synchronous replication; no port advances alone).
REQ-015 On a tail transfer in XFER, sa_release SHALL pulse = lock for one cycle, lock SHALL clear, and the block SHALL return to IDLE; a new head SHALL be accepted no earlier than the following cycle.
REQ-016 In DROP, in_ready SHALL be 1 and out_valid 0 until a tail is consumed, then the block SHALL return to IDLE.
REQ-017 port_dst SHALL be held stable from ALLOC entry until IDLE re-entry.
REQ-018 Minimum head latency SHALL be: head seen at cycle t, sa_req at t+1, grants at t+1, out_valid at t+2.

Reset
REQ-019 During rst, the block SHALL set state=IDLE and clear lock, branch and port_dst; sa_req, sa_release, out_valid, in_ready and err_orphan SHALL be 0.
REQ-020 Reset mid-packet SHALL abandon the packet without a sa_release pulse; the allocator is reset by the same rst.

Structure
REQ-021 Port index constants (L/N/E/S/W), the port count and the state encoding SHALL reside in the shared define/package file.
REQ-022 SHALL use one combinational sub-module, mcast_partition (in_dst → 5 slices), reused by u_mesh_algorithm-based checks.

Verification
REQ-023 With MY=(0,1), 4x4 mesh, head in_dst=16'h0031 → port_dst L=16'h0010, E=16'h0020, S=16'h0001; sa_req=5'b01101 at t+1.
REQ-024 Same packet with E granted at t+1, L at t+2, S at t+4 → sa_req drops each granted bit the cycle after its grant; out_valid=5'b01101 at t+5.
REQ-025 3-flit packet in XFER with out_ready[3]=0 for 2 cycles → in_ready=0 for those cycles, no duplicate flit on L or E; sa_release=5'b01101 for one cycle after the tail.
REQ-026 Head with in_dst=0 followed by 2 body flits and a tail → all consumed, out_valid never set, back in IDLE.
REQ-027 Body flit in IDLE → err_orphan pulses one cycle and the flit is consumed; rst asserted mid-XFER → next cycle all outputs are 0 and there is no sa_release.

Source files
------------

// File: rtl/mcast_branch_sched_pkg.sv
// rtl/mcast_branch_sched_pkg.sv - shared port indices and FSM encoding for the multicast branch scheduler
package mcast_branch_sched_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_L    = 0;
  localparam int PORT_N    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_XFER  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // Dimension-ordered (X first, then Y) output port for a destination node.
  function automatic int route_port(input int x, input int y, input int my_x, input int my_y);
    if (x > my_x)      return PORT_E;
    else if (x < my_x) return PORT_W;
    else if (y > my_y) return PORT_N;
    else if (y < my_y) return PORT_S;
    else               return PORT_L;
  endfunction

endpackage

// File: rtl/mcast_branch_sched_partition.sv
// rtl/mcast_branch_sched_partition.sv - combinational split of a multicast bitmask into per-port branch masks
module mcast_partition
  import mcast_branch_sched_pkg::*;
#(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int XDIM    = 4,
  parameter int YDIM    = 4
) (
  input  logic [XDIM*YDIM-1:0]           i_dst,
  output logic [NUM_PORTS*XDIM*YDIM-1:0] o_port_dst,
  output logic [NUM_PORTS-1:0]           o_branch
);

  localparam int NN = XDIM * YDIM;

  for (genvar n = 0; n < NN; n++) begin : g_node
    localparam int X = n % XDIM;
    localparam int Y = n / XDIM;
    localparam int P = route_port(X, Y, MY_XPOS, MY_YPOS);
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      if (p == P) begin : g_hit
        assign o_port_dst[p*NN+n] = i_dst[n];
      end else begin : g_miss
        assign o_port_dst[p*NN+n] = 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_branch
    assign o_branch[p] = |o_port_dst[p*NN +: NN];
  end

endmodule

// File: rtl/mcast_branch_sched.sv
// rtl/mcast_branch_sched.sv - multicast branch scheduler: partitions a head, collects all port grants, replicates flits in lockstep
module mcast_branch_sched
  import mcast_branch_sched_pkg::*;
#(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int XDIM    = 4,
  parameter int YDIM    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_head,
  input  logic                           in_tail,
  input  logic [XDIM*YDIM-1:0]           in_dst,
  output logic [NUM_PORTS-1:0]           sa_req,
  input  logic [NUM_PORTS-1:0]           sa_gnt,
  output logic [NUM_PORTS-1:0]           sa_release,
  output logic [NUM_PORTS*XDIM*YDIM-1:0] port_dst,
  output logic [NUM_PORTS-1:0]           out_valid,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic                           err_orphan
);

  localparam int NN = XDIM * YDIM;

  state_t                     r_state;
  logic [NUM_PORTS-1:0]       r_lock;
  logic [NUM_PORTS-1:0]       r_branch;
  logic [NUM_PORTS*NN-1:0]    r_port_dst;
  logic [NUM_PORTS-1:0]       r_sa_release;

  logic [NUM_PORTS*NN-1:0]    w_slices;
  logic [NUM_PORTS-1:0]       w_branch;
  logic [NUM_PORTS-1:0]       w_lock_nxt;

  mcast_partition #(
    .MY_XPOS (MY_XPOS),
    .MY_YPOS (MY_YPOS),
    .XDIM    (XDIM),
    .YDIM    (YDIM)
  ) u_partition (
    .i_dst      (in_dst),
    .o_port_dst (w_slices),
    .o_branch   (w_branch)
  );

  // Handshake outputs are forced low while rst is held so nothing leaks mid-packet.
  always_comb begin
    sa_req     = '0;
    out_valid  = '0;
    in_ready   = 1'b0;
    err_orphan = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && !in_head) begin
            in_ready   = 1'b1;
            err_orphan = 1'b1;
          end
        end
        ST_ALLOC: sa_req = r_branch & ~r_lock;
        ST_XFER: begin
          out_valid = r_lock & {NUM_PORTS{in_valid}};
          in_ready  = &(out_ready | ~r_lock);
        end
        ST_DROP:  in_ready = 1'b1;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign w_lock_nxt = r_lock | (sa_gnt & sa_req);
  assign port_dst   = r_port_dst;
  assign sa_release = r_sa_release;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lock       <= '0;
      r_branch     <= '0;
      r_port_dst   <= '0;
      r_sa_release <= '0;
    end else begin
      r_sa_release <= '0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_head) begin
            r_port_dst <= w_slices;
            r_branch   <= w_branch;
            r_state    <= (|w_branch) ? ST_ALLOC : ST_DROP;
          end
        end
        ST_ALLOC: begin
          r_lock <= w_lock_nxt;
          // Same-cycle grant completion moves straight to XFER, giving out_valid two cycles after the head.
          if (w_lock_nxt == r_branch) r_state <= ST_XFER;
        end
        ST_XFER: begin
          if (in_valid && in_ready && in_tail) begin
            r_sa_release <= r_lock;
            r_lock       <= '0;
            r_state      <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (in_valid && in_tail) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcast_branch_sched.sv
// tb/tb_mcast_branch_sched.sv - directed self-checking bench for mcast_branch_sched at router (0,1) of a 4x4 mesh
module tb_mcast_branch_sched;

  localparam int NN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_head;
  logic          in_tail;
  logic [NN-1:0] in_dst;
  logic [4:0]    sa_req;
  logic [4:0]    sa_gnt;
  logic [4:0]    sa_release;
  logic [5*NN-1:0] port_dst;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready;
  logic          err_orphan;

  int n_checks = 0;
  int n_errors = 0;

  mcast_branch_sched #(
    .MY_XPOS (0),
    .MY_YPOS (1),
    .XDIM    (4),
    .YDIM    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_head    (in_head),
    .in_tail    (in_tail),
    .in_dst     (in_dst),
    .sa_req     (sa_req),
    .sa_gnt     (sa_gnt),
    .sa_release (sa_release),
    .port_dst   (port_dst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sa_req"},     80'(sa_req),     80'h0);
    check({tag, "_sa_release"}, 80'(sa_release), 80'h0);
    check({tag, "_out_valid"},  80'(out_valid),  80'h0);
    check({tag, "_in_ready"},   80'(in_ready),   80'h0);
    check({tag, "_err_orphan"}, 80'(err_orphan), 80'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
    in_dst = '0; sa_gnt = '0; out_ready = 5'h1f;
    tick; tick;
    check_quiet("reset");
    check("reset_port_dst", port_dst, 80'h0);
    in_valid = 1'b1; #1;
    check("reset_no_orphan", 80'(err_orphan), 80'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick;

    // Three-flit multicast to nodes 0,4,5 with staggered grants and a downstream stall.
    in_valid = 1'b1; in_head = 1'b1; in_dst = 16'h0031; #1;
    check("t0_head_held", 80'(in_ready), 80'h0);
    tick;
    check("t1_port_dst", port_dst, {16'h0000, 16'h0001, 16'h0020, 16'h0000, 16'h0010});
    check("t1_sa_req", 80'(sa_req), 80'h0d);
    sa_gnt = 5'b00100;
    tick;
    check("t2_sa_req", 80'(sa_req), 80'h09);
    sa_gnt = 5'b00001;
    tick;
    check("t3_sa_req", 80'(sa_req), 80'h08);
    sa_gnt = 5'b10010;
    tick;
    check("t4_sa_req_unreq_gnt", 80'(sa_req), 80'h08);
    check("t4_out_valid", 80'(out_valid), 80'h0);
    sa_gnt = 5'b01000;
    tick;
    sa_gnt = 5'b00000; #1;
    check("t5_sa_req", 80'(sa_req), 80'h0);
    check("t5_out_valid", 80'(out_valid), 80'h0d);
    check("t5_in_ready", 80'(in_ready), 80'h1);
    tick;
    in_head = 1'b0; out_ready = 5'b10111; #1;
    check("stall1_in_ready", 80'(in_ready), 80'h0);
    tick;
    check("stall2_in_ready", 80'(in_ready), 80'h0);
    check("stall2_port_dst", port_dst, {16'h0000, 16'h0001, 16'h0020, 16'h0000, 16'h0010});
    out_ready = 5'h1f; #1;
    check("body_in_ready", 80'(in_ready), 80'h1);
    tick;
    in_tail = 1'b1; #1;
    check("tail_in_ready", 80'(in_ready), 80'h1);
    check("tail_no_release", 80'(sa_release), 80'h0);
    tick;
    in_valid = 1'b0; in_tail = 1'b0; #1;
    check("release_pulse", 80'(sa_release), 80'h0d);
    check("release_out_valid", 80'(out_valid), 80'h0);
    tick;
    check("release_done", 80'(sa_release), 80'h0);

    // Single-flit packet to the local node: minimum latency.
    in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_dst = 16'h0010; #1;
    check("lat_head_held", 80'(in_ready), 80'h0);
    tick;
    check("lat_sa_req", 80'(sa_req), 80'h01);
    sa_gnt = 5'b00001;
    tick;
    sa_gnt = 5'b00000; #1;
    check("lat_out_valid", 80'(out_valid), 80'h01);
    check("lat_in_ready", 80'(in_ready), 80'h1);
    tick;
    in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0; #1;
    check("lat_release", 80'(sa_release), 80'h01);
    tick;

    // Empty destination set: whole packet is dropped.
    in_valid = 1'b1; in_head = 1'b1; in_dst = 16'h0000; #1;
    check("drop_head_held", 80'(in_ready), 80'h0);
    tick;
    check("drop_head_ready", 80'(in_ready), 80'h1);
    check("drop_head_ov", 80'(out_valid), 80'h0);
    check("drop_head_req", 80'(sa_req), 80'h0);
    tick;
    in_head = 1'b0; #1;
    check("drop_body1_ready", 80'(in_ready), 80'h1);
    tick;
    check("drop_body2_ready", 80'(in_ready), 80'h1);
    check("drop_body2_ov", 80'(out_valid), 80'h0);
    tick;
    in_tail = 1'b1; #1;
    check("drop_tail_ready", 80'(in_ready), 80'h1);
    tick;
    in_tail = 1'b0; #1;
    check("orphan_pulse", 80'(err_orphan), 80'h1);
    check("orphan_consumed", 80'(in_ready), 80'h1);
    check("orphan_ov", 80'(out_valid), 80'h0);
    tick;
    in_valid = 1'b0; #1;
    check("orphan_clear", 80'(err_orphan), 80'h0);

    // North/East branches, then reset while stalled in XFER.
    in_valid = 1'b1; in_head = 1'b1; in_dst = 16'h8100;
    tick;
    check("ne_port_dst", port_dst, {16'h0000, 16'h0000, 16'h8000, 16'h0100, 16'h0000});
    check("ne_sa_req", 80'(sa_req), 80'h06);
    sa_gnt = 5'b00110;
    tick;
    sa_gnt = 5'b00000; out_ready = 5'b00000; #1;
    check("ne_out_valid", 80'(out_valid), 80'h06);
    check("ne_in_ready", 80'(in_ready), 80'h0);
    rst = 1'b1;
    tick;
    check_quiet("midrst");
    in_valid = 1'b0; in_head = 1'b0; rst = 1'b0; out_ready = 5'h1f;
    tick;
    check_quiet("postrst");
    check("postrst_port_dst", port_dst, 80'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
